pong_game_control: RTL and testbench
====================================

Name: pong_game_control

Overview:
Top-level game sequencer for the Pong ball horizontal circuit. It owns the attract/serve/score state, the serve-delay timing and both players' scores. It drives serve, attract, _attract, rst_speed and sc into the ball horizontal logic. It consumes ball-miss (ball left playfield) indications and a coin/start strobe.

Parameters:
WIN_SCORE, 11, score at which a game ends; legal range 1..15.
SERVE_FRAMES, 100, number of vreset pulses the serve is held off after start or a point; legal range 1..255.

Ports:
clk7_159  input  1  system clock; all logic on rising edge.
rst  input  1  reset; synchronous, active-high.
vreset  input  1  one-clock frame strobe, once per field.
coin  input  1  start request, level; rising edge acts.
miss_l  input  1  ball past left edge, level; point to right player.
miss_r  input  1  ball past right edge, level; point to left player.
attract  output  1  high while no game is in progress.
_attract  output  1  always the inverse of attract.
serve  output  1  high while the ball is live.
rst_speed  output  1  one-clock pulse; resets ball speed.
sc  output  1  one-clock score pulse.
score_l  output  4  left player score, unsigned binary.
score_r  output  4  right player score, unsigned binary.

Behaviour:
- Reset (rst=1 at an edge):
  - state=ATTRACT, attract=1, _attract=0, serve=1.
  - rst_speed=0, sc=0, score_l=score_r=0.
  - Frame counter=0; edge-detect registers for coin/miss_l/miss_r cleared to 0.
  - rst overrides every other input, including mid-serve-wait or mid-score.
- All outputs are registered; no combinational input-to-output paths.
- Edge detection: input X "rises" at edge k if X=1 at k and X=0 at k-1. A level held high never re-triggers.
- States and transitions:
  - ATTRACT:
    - Outputs: attract=1, serve=1 (ball free-runs).
    - miss_l/miss_r ignored; scores hold the last game's values.
    - coin rise -> START.
  - START (1 cycle):
    - score_l=score_r=0, frame counter=0.
    - attract drops to 0 in this cycle; serve=0.
    - -> SERVE_WAIT.
  - SERVE_WAIT:
    - serve=0.
    - rst_speed=1 on the first cycle of SERVE_WAIT only.
    - Each vreset increments the frame counter (8-bit).
    - When the counter reaches SERVE_FRAMES: clear the counter, -> PLAY (serve=1 from the next cycle).
    - miss_l/miss_r/coin ignored.
  - PLAY:
    - serve=1.
    - miss_l rise: latch side=R, -> SCORE.
    - Else miss_r rise: latch side=L, -> SCORE.
    - Simultaneous rises: miss_l wins; miss_r is discarded.
    - coin ignored.
  - SCORE (1 cycle):
    - sc=1, serve=0.
    - Latched side's score increments by 1 at the end of this cycle.
    - If the new value == WIN_SCORE -> ATTRACT.
    - Else -> SERVE_WAIT.
- Latency:
  - Miss rise sampled at edge k:
    - serve=0 and sc=1 during cycle k+1.
    - New score visible, sc=0 and rst_speed=1 (if not game over) during cycle k+2.
  - coin rise at edge k: attract=0 during k+1; rst_speed=1 during k+2.
- Scores saturate at WIN_SCORE (no wrap); the game always ends exactly at WIN_SCORE.
- vreset during START or SCORE is not counted.
- rst_speed and sc are never high in the same cycle.
- Both are never high for more than one consecutive cycle.

Test Plan:
1. Reset with all inputs 0 -> attract=1, _attract=0, serve=1, scores 0/0, rst_speed=0, sc=0; hold 1000 cycles with miss_l/miss_r toggling -> no change.
2. SERVE_FRAMES=3: coin rise at edge k -> attract=0 at k+1, rst_speed=1 for exactly cycle k+2; serve stays 0 until the 3rd subsequent vreset, then serve=1 the cycle after.
3. In PLAY, miss_l rises and is held high 50 cycles -> sc=1 for one cycle, score_r 0->1 once only, rst_speed pulse, serve=0 for SERVE_FRAMES frames.
4. In PLAY, miss_l and miss_r rise on the same edge -> score_r+1, score_l unchanged.
5. WIN_SCORE=2: two miss_r points -> score_l=2, attract=1, serve=1, no rst_speed pulse; scores hold 2/0 until the next coin, which clears them to 0/0.
6. rst asserted for one edge during SERVE_WAIT with scores 1/1 -> next cycle ATTRACT, scores 0/0, counter 0; coin during PLAY and SERVE_WAIT has no effect.

Source files
------------

// File: rtl/pong_game_control_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_control_if
// Description : Signal bundle between the Pong game sequencer and the ball
//               horizontal circuit / cabinet inputs. The master drives the
//               frame strobe, coin and miss indications; the slave (the
//               sequencer) drives the game-state outputs and both scores.
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_game_control_if;
    logic       vreset;
    logic       coin;
    logic       miss_l;
    logic       miss_r;
    logic       attract;
    logic       _attract;
    logic       serve;
    logic       rst_speed;
    logic       sc;
    logic [3:0] score_l;
    logic [3:0] score_r;

    modport master (
        output vreset, coin, miss_l, miss_r,
        input  attract, _attract, serve, rst_speed, sc, score_l, score_r
    );

    modport slave (
        input  vreset, coin, miss_l, miss_r,
        output attract, _attract, serve, rst_speed, sc, score_l, score_r
    );
endinterface
`default_nettype wire

// File: rtl/pong_game_control.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_control
// Description : Pong game sequencer. Runs attract / start / serve-wait /
//               play / score, times the serve hold-off in frames and keeps
//               both players' scores. Every output is a flop.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_control #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 100
) (
    input  logic              clk7_159,
    input  logic              rst,
    pong_game_control_if.slave bus
);

    localparam logic [4:0] c_win    = 5'(WIN_SCORE);
    localparam logic [7:0] c_frames = 8'(SERVE_FRAMES);

    typedef enum logic [2:0] {
        c_st_attract = 3'd0,
        c_st_start   = 3'd1,
        c_st_wait    = 3'd2,
        c_st_play    = 3'd3,
        c_st_score   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_cnt;
    logic       r_coin_d;
    logic       r_miss_l_d;
    logic       r_miss_r_d;
    logic       r_side_r;
    logic [3:0] r_score_l;
    logic [3:0] r_score_r;
    logic       r_attract;
    logic       r_attract_n;
    logic       r_serve;
    logic       r_rst_speed;
    logic       r_sc;

    logic       w_coin_rise;
    logic       w_miss_l_rise;
    logic       w_miss_r_rise;
    logic [7:0] w_cnt_inc;
    logic       w_frame_done;
    logic [4:0] w_pts_raw;
    logic [4:0] w_pts;
    logic       w_game_over;
    logic       w_attract_nxt;
    logic       w_serve_nxt;
    logic       w_rst_speed_nxt;
    logic       w_sc_nxt;

    assign w_coin_rise   = bus.coin   & ~r_coin_d;
    assign w_miss_l_rise = bus.miss_l & ~r_miss_l_d;
    assign w_miss_r_rise = bus.miss_r & ~r_miss_r_d;

    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_frame_done = bus.vreset && (w_cnt_inc == c_frames);

    // Point value for the side that just scored, capped so it can never pass
    // the winning score.
    assign w_pts_raw   = {1'b0, (r_side_r ? r_score_r : r_score_l)} + 5'd1;
    assign w_pts       = (w_pts_raw > c_win) ? c_win : w_pts_raw;
    assign w_game_over = (w_pts == c_win);

    // State register.
    always_ff @(posedge clk7_159) begin
        if (rst) r_state <= c_st_attract;
        else     r_state <= w_state_nxt;
    end

    // Next state, plus output values decoded from the state being entered so
    // the outputs can be registered without adding a cycle of latency.
    always_comb begin
        w_state_nxt     = r_state;
        w_attract_nxt   = 1'b0;
        w_serve_nxt     = 1'b0;
        w_rst_speed_nxt = 1'b0;
        w_sc_nxt        = 1'b0;
        case (r_state)
            c_st_attract: if (w_coin_rise) w_state_nxt = c_st_start;
            c_st_start:   w_state_nxt = c_st_wait;
            c_st_wait:    if (w_frame_done) w_state_nxt = c_st_play;
            c_st_play:    if (w_miss_l_rise || w_miss_r_rise) w_state_nxt = c_st_score;
            c_st_score:   w_state_nxt = w_game_over ? c_st_attract : c_st_wait;
            default:      w_state_nxt = c_st_attract;
        endcase
        w_attract_nxt   = (w_state_nxt == c_st_attract);
        w_serve_nxt     = (w_state_nxt == c_st_attract) || (w_state_nxt == c_st_play);
        w_rst_speed_nxt = (w_state_nxt == c_st_wait) && (r_state != c_st_wait);
        w_sc_nxt        = (w_state_nxt == c_st_score);
    end

    // Previous-cycle copies of the level inputs for rise detection.
    always_ff @(posedge clk7_159) begin
        if (rst) begin
            r_coin_d   <= 1'b0;
            r_miss_l_d <= 1'b0;
            r_miss_r_d <= 1'b0;
        end else begin
            r_coin_d   <= bus.coin;
            r_miss_l_d <= bus.miss_l;
            r_miss_r_d <= bus.miss_r;
        end
    end

    // Serve hold-off frame counter; only vreset pulses seen in serve-wait count.
    always_ff @(posedge clk7_159) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (r_state == c_st_attract && w_coin_rise) begin
            r_cnt <= 8'd0;
        end else if (r_state == c_st_wait && bus.vreset) begin
            r_cnt <= w_frame_done ? 8'd0 : w_cnt_inc;
        end
    end

    // Scores and the side that is owed the pending point.
    always_ff @(posedge clk7_159) begin
        if (rst) begin
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
            r_side_r  <= 1'b0;
        end else begin
            case (r_state)
                c_st_attract: begin
                    if (w_coin_rise) begin
                        r_score_l <= 4'd0;
                        r_score_r <= 4'd0;
                    end
                end
                c_st_play: begin
                    // A left miss wins a tie, so the right player scores.
                    if (w_miss_l_rise)      r_side_r <= 1'b1;
                    else if (w_miss_r_rise) r_side_r <= 1'b0;
                end
                c_st_score: begin
                    if (r_side_r) r_score_r <= w_pts[3:0];
                    else          r_score_l <= w_pts[3:0];
                end
                default: ;
            endcase
        end
    end

    // Registered game-state outputs.
    always_ff @(posedge clk7_159) begin
        if (rst) begin
            r_attract   <= 1'b1;
            r_attract_n <= 1'b0;
            r_serve     <= 1'b1;
            r_rst_speed <= 1'b0;
            r_sc        <= 1'b0;
        end else begin
            r_attract   <= w_attract_nxt;
            r_attract_n <= ~w_attract_nxt;
            r_serve     <= w_serve_nxt;
            r_rst_speed <= w_rst_speed_nxt;
            r_sc        <= w_sc_nxt;
        end
    end

    assign bus.attract   = r_attract;
    assign bus._attract  = r_attract_n;
    assign bus.serve     = r_serve;
    assign bus.rst_speed = r_rst_speed;
    assign bus.sc        = r_sc;
    assign bus.score_l   = r_score_l;
    assign bus.score_r   = r_score_r;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_control
// Description : Self-checking bench for pong_game_control: a directed vector
//               table, hand sequences and randomized play compared against a
//               frame-countdown game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_control;

    localparam int WIN = 3;
    localparam int SF  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pong_game_control_if bus ();

    pong_game_control #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SF)
    ) dut (
        .clk7_159 (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    // Game phases: idle (no game), starting, waiting for serve, live ball,
    // awarding a point.
    localparam int M_IDLE  = 0;
    localparam int M_START = 1;
    localparam int M_WAIT  = 2;
    localparam int M_LIVE  = 3;
    localparam int M_POINT = 4;

    int mode      = M_IDLE;
    int left      = 0;   // frames still to wait before the serve
    bit fresh     = 0;   // first cycle of a serve wait
    bit to_right  = 0;
    int sl        = 0;
    int sr        = 0;
    bit pc = 0, pml = 0, pmr = 0;

    task automatic model_edge(input bit r, input bit c, input bit l, input bit m, input bit v);
        bit c_up, l_up, m_up;
        if (r) begin
            mode = M_IDLE; sl = 0; sr = 0; fresh = 0; left = 0;
            pc = 0; pml = 0; pmr = 0;
            return;
        end
        c_up = c && !pc;
        l_up = l && !pml;
        m_up = m && !pmr;
        pc = c; pml = l; pmr = m;
        fresh = 0;
        if (mode == M_IDLE) begin
            if (c_up) begin mode = M_START; sl = 0; sr = 0; end
        end else if (mode == M_START) begin
            mode = M_WAIT; left = SF; fresh = 1;
        end else if (mode == M_WAIT) begin
            if (v) begin
                left = left - 1;
                if (left == 0) mode = M_LIVE;
            end
        end else if (mode == M_LIVE) begin
            if (l_up)      begin mode = M_POINT; to_right = 1; end
            else if (m_up) begin mode = M_POINT; to_right = 0; end
        end else begin
            if (to_right) sr = (sr + 1 > WIN) ? WIN : sr + 1;
            else          sl = (sl + 1 > WIN) ? WIN : sl + 1;
            if (sl == WIN || sr == WIN) mode = M_IDLE;
            else begin mode = M_WAIT; left = SF; fresh = 1; end
        end
    endtask

    function automatic logic [12:0] model_vec();
        bit a;
        a = (mode == M_IDLE);
        return {a, !a, (mode == M_IDLE) || (mode == M_LIVE), fresh,
                (mode == M_POINT), 4'(sl), 4'(sr)};
    endfunction

    // ---------------- drive / compare ----------------
    task automatic apply(input bit r, input bit c, input bit l, input bit m, input bit v);
        rst        = r;
        bus.coin   = c;
        bus.miss_l = l;
        bus.miss_r = m;
        bus.vreset = v;
        @(posedge clk);
        model_edge(r, c, l, m, v);
        cyc++;
        #1;
    endtask

    task automatic check(input string nm, input logic [12:0] exp);
        logic [12:0] got;
        got = {bus.attract, bus._attract, bus.serve, bus.rst_speed, bus.sc,
               bus.score_l, bus.score_r};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got {att,_att,serve,rs,sc,sl,sr}=%b required %b",
                     nm, cyc, got, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        bit       r, c, l, m, v;
        bit       a, s, rs, sc;
        bit [3:0] sl, sr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit c, bit l, bit m, bit v,
                                bit a, bit s, bit rs, bit sc, int el, int er);
        vec_t t;
        t.r = r; t.c = c; t.l = l; t.m = m; t.v = v;
        t.a = a; t.s = s; t.rs = rs; t.sc = sc;
        t.sl = 4'(el); t.sr = 4'(er);
        return t;
    endfunction

    initial begin
        bit ml, mr, cn, vr, rr;
        bus.coin = 0; bus.miss_l = 0; bus.miss_r = 0; bus.vreset = 0;

        //            rst c l m v   att srv rs sc  sl sr
        tbl.push_back(mk(1,0,0,0,0, 1,1,0,0, 0,0)); // reset
        tbl.push_back(mk(0,0,1,0,0, 1,1,0,0, 0,0)); // misses ignored in attract
        tbl.push_back(mk(0,0,0,1,0, 1,1,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, 0,0)); // coin rise -> start
        tbl.push_back(mk(0,1,0,0,1, 0,0,1,0, 0,0)); // wait entry, vreset in start not counted
        tbl.push_back(mk(0,1,0,0,1, 0,0,0,0, 0,0)); // frame 1
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0,1, 0,0,0,0, 0,0)); // frame 2, coin ignored
        tbl.push_back(mk(0,0,0,0,1, 0,1,0,0, 0,0)); // frame 3 -> play
        tbl.push_back(mk(0,1,0,0,0, 0,1,0,0, 0,0)); // coin in play ignored
        tbl.push_back(mk(0,0,1,1,0, 0,0,0,1, 0,0)); // simultaneous misses
        tbl.push_back(mk(0,0,1,1,0, 0,0,1,0, 0,1)); // left miss wins -> right +1
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0, 0,1));
        tbl.push_back(mk(0,0,1,0,1, 0,0,0,0, 0,1));
        tbl.push_back(mk(0,0,1,0,1, 0,1,0,0, 0,1)); // play, miss_l still held
        tbl.push_back(mk(0,0,1,0,0, 0,1,0,0, 0,1)); // held level does not retrigger
        tbl.push_back(mk(0,0,1,1,0, 0,0,0,1, 0,1)); // miss_r rise
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0, 1,1));
        tbl.push_back(mk(1,0,0,0,0, 1,1,0,0, 0,0)); // reset during serve wait
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0, 0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0, 0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0,1, 0,1,0,0, 0,0));
        tbl.push_back(mk(0,0,0,1,0, 0,0,0,1, 0,0)); // left point 1
        tbl.push_back(mk(0,0,0,1,0, 0,0,1,0, 1,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0, 1,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0, 1,0));
        tbl.push_back(mk(0,0,0,0,1, 0,1,0,0, 1,0));
        tbl.push_back(mk(0,0,0,1,0, 0,0,0,1, 1,0)); // left point 2
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0, 2,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0, 2,0));
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0, 2,0));
        tbl.push_back(mk(0,0,0,0,1, 0,1,0,0, 2,0));
        tbl.push_back(mk(0,0,0,1,0, 0,0,0,1, 2,0)); // left point 3 = win
        tbl.push_back(mk(0,0,0,0,0, 1,1,0,0, 3,0)); // game over, no rst_speed
        tbl.push_back(mk(0,0,1,0,0, 1,1,0,0, 3,0)); // scores hold in attract
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0, 0,0)); // new coin clears scores
        tbl.push_back(mk(0,0,0,0,0, 0,0,1,0, 0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].m, tbl[i].v);
            check($sformatf("vec%0d", i),
                  {tbl[i].a, !tbl[i].a, tbl[i].s, tbl[i].rs, tbl[i].sc, tbl[i].sl, tbl[i].sr});
        end

        // Attract hold: misses toggling for 1000 cycles change nothing.
        apply(1, 0, 0, 0, 0);
        check("hold_reset", model_vec());
        for (int i = 0; i < 1000; i++) begin
            apply(0, 0, i[0], i[1], ($urandom_range(0, 3) == 0));
            check("attract_hold", model_vec());
        end

        // Start a game, then hold miss_l high for 50 cycles.
        apply(0, 1, 0, 0, 0);
        check("seq_start", model_vec());
        apply(0, 0, 0, 0, 0);
        check("seq_wait", model_vec());
        for (int i = 0; i < SF; i++) begin
            apply(0, 0, 0, 0, 1);
            check("seq_frames", model_vec());
        end
        for (int i = 0; i < 50; i++) begin
            apply(0, 0, 1, 0, (i % 2 == 1));
            check("miss_l_held", model_vec());
        end

        // Randomized play against the model.
        ml = 0; mr = 0; cn = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)  ml = !ml;
            if ($urandom_range(0, 7) == 0)  mr = !mr;
            if ($urandom_range(0, 15) == 0) cn = !cn;
            vr = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 999) == 0);
            apply(rr, cn, ml, mr, vr);
            check("random", model_vec());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
